// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types, opcode/cond constants and opcode mapping for alu_issue_ctrl
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [4:0] ALU_AND = 5'b01000, ALU_EOR = 5'b01001, ALU_SUB = 5'b01010;
  localparam logic [4:0] ALU_RSB = 5'b00011, ALU_ADD = 5'b01011, ALU_ADC = 5'b00101;
  localparam logic [4:0] ALU_SBC = 5'b00110, ALU_RSC = 5'b00111, ALU_ORR = 5'b01100;
  localparam logic [4:0] ALU_MOV = 5'b01101, ALU_BIC = 5'b01110;
  localparam logic [4:0] ALU_PC_A = 5'b10000, ALU_PC_A4 = 5'b10001, ALU_PC_AB4 = 5'b10010;
  localparam logic [4:0] ALU_NONE = 5'b00000;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

  function automatic logic [4:0] map_dp_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_TST: return ALU_AND;
      OP_EOR, OP_TEQ: return ALU_EOR;
      OP_SUB, OP_CMP: return ALU_SUB;
      OP_RSB:         return ALU_RSB;
      OP_ADD, OP_CMN: return ALU_ADD;
      OP_ADC:         return ALU_ADC;
      OP_SBC:         return ALU_SBC;
      OP_RSC:         return ALU_RSC;
      OP_ORR:         return ALU_ORR;
      OP_BIC:         return ALU_BIC;
      default:        return ALU_MOV;
    endcase
  endfunction

  function automatic logic [4:0] map_pc_mode(input logic [1:0] mode);
    case (mode)
      2'b00:   return ALU_PC_A;
      2'b01:   return ALU_PC_A4;
      2'b10:   return ALU_PC_AB4;
      default: return ALU_NONE;
    endcase
  endfunction

  // Compare/test ops always set flags and never write back.
  function automatic logic is_test(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - operand/result bus between the issue controller and the shared ALU
interface alu_issue_ctrl_if #(
  parameter int W   = 32,
  parameter int OPW = 5
);
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic           alu_cin;
  logic [W-1:0]   alu_out;
  logic           alu_c;
  logic           alu_z;
  logic           alu_n;
  logic           alu_v;

  modport master (
    output alu_a, alu_b, alu_op, alu_cin,
    input  alu_out, alu_c, alu_z, alu_n, alu_v
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_cin,
    output alu_out, alu_c, alu_z, alu_n, alu_v
  );
endinterface

// File: rtl/alu_issue_ctrl_cond_check.sv
// rtl/alu_issue_ctrl_cond_check.sv - ARM condition-field evaluation against {N,Z,C,V}
module cond_check
  import alu_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - round-robin DP/PC issue to a shared ALU; COND_EXEC_EN enables the condition-skip path
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dp_valid,
  output logic             dp_ready,
  input  logic [3:0]       dp_cond,
  input  logic [3:0]       dp_op,
  input  logic             dp_s,
  input  logic [W-1:0]     dp_a,
  input  logic [W-1:0]     dp_b,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic [1:0]       pc_mode,
  input  logic [W-1:0]     pc_a,
  input  logic [W-1:0]     pc_b,
  alu_issue_ctrl_if.master alu,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_src,
  output logic             rsp_wb,
  output logic [3:0]       flags
);
  state_t         state, state_nx;
  logic           last_pc;
  logic           grant_dp, grant_pc;
  logic           cond_pass, cond_ok;
  logic [3:0]     lat_op;
  logic           lat_s;
  logic [W-1:0]   a_q, b_q;
  logic [OPW-1:0] op_q;

  cond_check u_cond (.cond(dp_cond), .nzcv(flags), .pass(cond_pass));

`ifdef COND_EXEC_EN
  assign cond_ok = cond_pass;
  logic unused_alu;
  assign unused_alu = ^{alu.alu_z, alu.alu_n};
`else
  assign cond_ok = 1'b1;
  logic unused_alu;
  assign unused_alu = ^{alu.alu_z, alu.alu_n, cond_pass};
`endif

  assign alu.alu_a   = a_q;
  assign alu.alu_b   = b_q;
  assign alu.alu_op  = op_q;
  assign alu.alu_cin = flags[1];
  assign dp_ready    = grant_dp;
  assign pc_ready    = grant_pc;
  assign rsp_valid   = (state == ST_RESP);

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    state_nx = state;
    grant_dp = 1'b0;
    grant_pc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!reset) begin
          grant_dp = dp_valid && (!pc_valid || last_pc);
          grant_pc = pc_valid && !grant_dp;
        end
        if (grant_dp)      state_nx = cond_ok ? ST_EXEC : ST_RESP;
        else if (grant_pc) state_nx = (pc_mode == 2'b11) ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last_pc  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      lat_op   <= '0;
      lat_s    <= 1'b0;
      rsp_data <= '0;
      rsp_src  <= 1'b0;
      rsp_wb   <= 1'b0;
      flags    <= '0;
    end else begin
      state <= state_nx;
      // Skipped/reserved requests go straight to RESP with the zeroed result set here.
      if (grant_dp) begin
        last_pc  <= 1'b0;
        rsp_src  <= 1'b0;
        lat_op   <= dp_op;
        lat_s    <= dp_s;
        a_q      <= dp_a;
        b_q      <= (dp_op == OP_MVN) ? ~dp_b : dp_b;
        op_q     <= map_dp_op(dp_op);
        rsp_data <= '0;
        rsp_wb   <= 1'b0;
      end else if (grant_pc) begin
        last_pc  <= 1'b1;
        rsp_src  <= 1'b1;
        lat_s    <= 1'b0;
        a_q      <= pc_a;
        b_q      <= pc_b;
        op_q     <= map_pc_mode(pc_mode);
        rsp_data <= '0;
        rsp_wb   <= 1'b0;
      end
      if (state == ST_EXEC) begin
        rsp_data <= alu.alu_out;
        rsp_wb   <= rsp_src || !is_test(lat_op);
        if (!rsp_src && (lat_s || is_test(lat_op))) begin
          flags <= {alu.alu_out[W-1], alu.alu_out == '0,
                    is_arith(lat_op) ? alu.alu_c : flags[1],
                    is_arith(lat_op) ? alu.alu_v : flags[0]};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dp_valid = 1'b0, dp_s = 1'b0, pc_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0]  dp_cond = 4'hE, dp_op = 4'h0;
  logic [31:0] dp_a = '0, dp_b = '0, pc_a = '0, pc_b = '0;
  logic [1:0]  pc_mode = 2'b00;
  logic        dp_ready, pc_ready, rsp_valid, rsp_src, rsp_wb;
  logic [31:0] rsp_data;
  logic [3:0]  flags;
  logic [33:0] stub_r;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_cond(dp_cond), .dp_op(dp_op), .dp_s(dp_s),
    .dp_a(dp_a), .dp_b(dp_b),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_mode(pc_mode), .pc_a(pc_a), .pc_b(pc_b),
    .alu(bus.master),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src),
    .rsp_wb(rsp_wb), .flags(flags)
  );

  // {carry, overflow, sum} of x + y + ci
  function automatic logic [33:0] addc(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    return {s[32], (x[31] == y[31]) && (s[31] != x[31]), s[31:0]};
  endfunction

  // ALU stand-in; logic codes return junk carry/overflow so a wrong flag source shows up.
  function automatic logic [33:0] alu_stub(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
    case (op)
      5'b01000: return {~ci, 1'b1, a & b};
      5'b01001: return {~ci, 1'b1, a ^ b};
      5'b01010: return addc(a, ~b, 1'b1);
      5'b00011: return addc(b, ~a, 1'b1);
      5'b01011: return addc(a, b, 1'b0);
      5'b00101: return addc(a, b, ci);
      5'b00110: return addc(a, ~b, ci);
      5'b00111: return addc(b, ~a, ci);
      5'b01100: return {~ci, 1'b1, a | b};
      5'b01101: return {~ci, 1'b1, b};
      5'b01110: return {~ci, 1'b1, a & ~b};
      5'b10000: return {2'b00, a};
      5'b10001: return {2'b00, a + 32'd4};
      5'b10010: return {2'b00, a + b + 32'd4};
      default:  return 34'd0;
    endcase
  endfunction

  assign stub_r       = alu_stub(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
  assign bus.alu_out  = stub_r[31:0];
  assign bus.alu_c    = stub_r[33];
  assign bus.alu_v    = stub_r[32];
  assign bus.alu_z    = (stub_r[31:0] == 32'd0);
  assign bus.alu_n    = stub_r[31];

  // ARM data-processing semantics, keyed on the architectural opcode.
  function automatic logic [33:0] ref_dp(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
    case (op)
      4'h0, 4'h8: return {2'b00, a & b};
      4'h1, 4'h9: return {2'b00, a ^ b};
      4'h2, 4'hA: return addc(a, ~b, 1'b1);
      4'h3:       return addc(b, ~a, 1'b1);
      4'h4, 4'hB: return addc(a, b, 1'b0);
      4'h5:       return addc(a, b, c);
      4'h6:       return addc(a, ~b, c);
      4'h7:       return addc(b, ~a, c);
      4'hC:       return {2'b00, a | b};
      4'hD:       return {2'b00, b};
      4'hE:       return {2'b00, a & ~b};
      default:    return {2'b00, ~b};
    endcase
  endfunction

  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;          4'h1: return !z;
      4'h2: return c;          4'h3: return !c;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return c && !z;    4'h9: return !c || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding request, result due a fixed number of cycles after accept.
  int          cyc = 0, due = 0;
  logic        busy = 1'b0, m_last_pc = 1'b1;
  logic        e_rv, e_dr, e_pr, e_src, e_wb, e_upd, pass;
  logic [31:0] e_data;
  logic [3:0]  m_flags = 4'h0, e_flags;
  logic [33:0] r;
  logic        arith, test;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      busy = 1'b0;
      m_flags = 4'h0;
      m_last_pc = 1'b1;
    end else begin
      if (busy && cyc == due && e_upd) m_flags = e_flags;
      e_rv = busy && (cyc >= due);
      e_dr = !busy && dp_valid && (!pc_valid || m_last_pc);
      e_pr = !busy && pc_valid && !e_dr;
      check1("m_dp_ready", dp_ready, e_dr);
      check1("m_pc_ready", pc_ready, e_pr);
      check1("m_rsp_valid", rsp_valid, e_rv);
      check32("m_flags", 32'(flags), 32'(m_flags));
      if (e_rv) begin
        check32("m_rsp_data", rsp_data, e_data);
        check1("m_rsp_src", rsp_src, e_src);
        check1("m_rsp_wb", rsp_wb, e_wb);
      end
      if (e_rv && rsp_ready) begin
        busy = 1'b0;
      end else if (e_dr) begin
        busy = 1'b1;
        m_last_pc = 1'b0;
        e_src = 1'b0;
`ifdef COND_EXEC_EN
        pass = ref_cond(dp_cond, m_flags);
`else
        pass = 1'b1;
`endif
        if (pass) begin
          r = ref_dp(dp_op, dp_a, dp_b, m_flags[1]);
          test = (dp_op >= 4'h8) && (dp_op <= 4'hB);
          arith = ((dp_op >= 4'h2) && (dp_op <= 4'h7)) || dp_op == 4'hA || dp_op == 4'hB;
          e_data = r[31:0];
          e_wb = !test;
          e_upd = dp_s || test;
          e_flags = {r[31], r[31:0] == 32'd0, arith ? r[33] : m_flags[1], arith ? r[32] : m_flags[0]};
          due = cyc + 2;
        end else begin
          e_data = 32'd0;
          e_wb = 1'b0;
          e_upd = 1'b0;
          due = cyc + 1;
        end
      end else if (e_pr) begin
        busy = 1'b1;
        m_last_pc = 1'b1;
        e_src = 1'b1;
        e_upd = 1'b0;
        e_wb = (pc_mode != 2'b11);
        due = (pc_mode == 2'b11) ? cyc + 1 : cyc + 2;
        case (pc_mode)
          2'b00:   e_data = pc_a;
          2'b01:   e_data = pc_a + 32'd4;
          2'b10:   e_data = pc_a + pc_b + 32'd4;
          default: e_data = 32'd0;
        endcase
      end
    end
  end

  task automatic send(input logic is_pc, input logic [3:0] cond, input logic [3:0] op, input logic s,
                      input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    if (is_pc) begin
      pc_valid = 1'b1; pc_mode = mode; pc_a = a; pc_b = b;
    end else begin
      dp_valid = 1'b1; dp_cond = cond; dp_op = op; dp_s = s; dp_a = a; dp_b = b;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = is_pc ? pc_ready : dp_ready;
    end
    check1("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    if (is_pc) pc_valid = 1'b0;
    else dp_valid = 1'b0;
  endtask

  task automatic get_rsp(output int lat, output logic [31:0] data, output logic wb,
                         output logic [3:0] fl, output logic src);
    lat = 0; data = '0; wb = 1'b0; fl = 4'h0; src = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; data = rsp_data; wb = rsp_wb; fl = flags; src = rsp_src;
        break;
      end
    end
    check1("rsp_timeout", lat != 0, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
      2:       return 32'($urandom_range(0, 8));
      3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  int          lat;
  logic [31:0] d;
  logic        wb, src, dacc, pacc;
  logic [3:0]  fl;
  logic [3:0]  srcs;
  logic [31:0] exp_d;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("reset_rsp_valid", rsp_valid, 1'b0);
    check1("reset_dp_ready", dp_ready, 1'b0);
    check32("reset_flags", 32'(flags), 32'h0);
    check32("reset_rsp_data", rsp_data, 32'h0);
    check32("reset_alu_op", 32'(bus.alu_op), 32'h0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // T1: ADD S=1 7+9
    send(1'b0, 4'hE, 4'h4, 1'b1, 2'b00, 32'd7, 32'd9);
    get_rsp(lat, d, wb, fl, src);
    check32("t1_latency", lat, 2);
    check32("t1_data", d, 32'd16);
    check1("t1_wb", wb, 1'b1);
    check32("t1_flags", 32'(fl), 32'h0);

    // T2: CMP 5,5 then EQ MOV 3
    send(1'b0, 4'hE, 4'hA, 1'b0, 2'b00, 32'd5, 32'd5);
    get_rsp(lat, d, wb, fl, src);
    check1("t2_cmp_wb", wb, 1'b0);
    check32("t2_cmp_flags", 32'(fl), 32'h6);
    send(1'b0, 4'h0, 4'hD, 1'b0, 2'b00, 32'd0, 32'd3);
    get_rsp(lat, d, wb, fl, src);
    check32("t2_mov_data", d, 32'd3);
    check32("t2_mov_latency", lat, 2);

    // T3: clear Z, then EQ ADD
    send(1'b0, 4'hE, 4'h4, 1'b1, 2'b00, 32'd1, 32'd1);
    get_rsp(lat, d, wb, fl, src);
    check32("t3_pre_flags", 32'(fl), 32'h0);
    send(1'b0, 4'h0, 4'h4, 1'b0, 2'b00, 32'd2, 32'd3);
    get_rsp(lat, d, wb, fl, src);
`ifdef COND_EXEC_EN
    check32("t3_skip_latency", lat, 1);
    check32("t3_skip_data", d, 32'd0);
    check1("t3_skip_wb", wb, 1'b0);
`else
    check32("t3_exec_latency", lat, 2);
    check32("t3_exec_data", d, 32'd5);
    check1("t3_exec_wb", wb, 1'b1);
`endif
    check32("t3_flags", 32'(fl), 32'h0);

    // T4: both requesters held high after reset alternate DP,PC,DP,PC
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    dp_valid = 1'b1; dp_cond = 4'hE; dp_op = 4'hD; dp_s = 1'b0; dp_a = 32'd0; dp_b = 32'd55;
    pc_valid = 1'b1; pc_mode = 2'b01; pc_a = 32'd100; pc_b = 32'd0;
    for (int k = 0; k < 4; k++) begin
      get_rsp(lat, d, wb, fl, src);
      srcs[k] = src;
      exp_d = src ? 32'd104 : 32'd55;
      check32("t4_data", d, exp_d);
    end
    dp_valid = 1'b0; pc_valid = 1'b0;
    check32("t4_grant_order", 32'(srcs), 32'hA);

    // T5: response stalled for 5 cycles
    rsp_ready = 1'b0;
    send(1'b0, 4'hE, 4'h4, 1'b0, 2'b00, 32'd1, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    @(posedge clk); #1;
    pc_valid = 1'b1; pc_mode = 2'b00; pc_a = 32'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("t5_hold_valid", rsp_valid, 1'b1);
      check32("t5_hold_data", rsp_data, 32'd3);
      check1("t5_no_ready", dp_ready | pc_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check1("t5_handshake_no_ready", pc_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check1("t5_idle_ready", pc_ready, 1'b1);
    @(posedge clk); #1;
    pc_valid = 1'b0;
    get_rsp(lat, d, wb, fl, src);
    check32("t5_pc_data", d, 32'd77);

    // T6: reset during EXEC discards the response
    rsp_ready = 1'b0;
    send(1'b0, 4'hE, 4'h4, 1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check32("t6_flags", 32'(flags), 32'h0);
    check32("t6_rsp_data", rsp_data, 32'h0);
    check32("t6_alu_op", 32'(bus.alu_op), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check1("t6_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Random phase; the reference model checks every cycle
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      dacc = dp_valid && dp_ready;
      pacc = pc_valid && pc_ready;
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; dp_valid = 1'b0; pc_valid = 1'b0;
      end
      if (!reset) begin
        if (!dp_valid || dacc) begin
          dp_valid = ($urandom_range(0, 2) != 0);
          dp_cond = 4'($urandom_range(0, 15));
          dp_op = 4'($urandom_range(0, 15));
          dp_s = 1'($urandom_range(0, 1));
          dp_a = rnd_operand();
          dp_b = ($urandom_range(0, 4) == 0) ? dp_a : rnd_operand();
        end
        if (!pc_valid || pacc) begin
          pc_valid = ($urandom_range(0, 2) == 0);
          pc_mode = 2'($urandom_range(0, 3));
          pc_a = $urandom;
          pc_b = $urandom;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    dp_valid = 1'b0; pc_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
